// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control encodings,
// FSM state encoding and the bit positions of the captured flags.
package alu_share_arbiter_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_AND  = 6'b000010;
    localparam logic [5:0] ALU_OR   = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_SLT  = 6'b000101;
    localparam logic [5:0] ALU_SLL  = 6'b000110;
    localparam logic [5:0] ALU_LUI  = 6'b000111;
    localparam logic [5:0] ALU_SRL  = 6'b001000;
    localparam logic [5:0] ALU_SRA  = 6'b001001;
    localparam logic [5:0] ALU_SLTU = 6'b001010;
    localparam logic [5:0] ALU_BNE  = 6'b001011;
    localparam logic [5:0] ALU_BGE  = 6'b001100;
    localparam logic [5:0] ALU_BGEU = 6'b001101;

    // rsp_flags = {carry, overflow, zero, negative}
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: ptr_i names the requester with
// highest priority, priority decreasing with increasing index modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round robin.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int XLEN  = 32,
    parameter int CTRLW = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*XLEN-1:0]  req_a,
    input  logic [NREQ*XLEN-1:0]  req_b,
    input  logic [NREQ*CTRLW-1:0] req_ctrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [XLEN-1:0]       rsp_result,
    output logic [3:0]            rsp_flags,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [CTRLW-1:0]      alu_ctrl,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_zero,
    input  logic                  alu_negative
);

    localparam int IDXW = (NREQ > 2) ? 2 : 1;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [CTRLW-1:0]  ctrl_q, ctrl_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_any;
    logic [IDXW-1:0]   arb_ptr;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDXW-1:0] ptr_q, ptr_d;

    // The winner drops to lowest priority for the next arbitration.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && arb_any) begin
            ptr_d = (arb_idx == IDXW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        flags_d   = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    a_d       = req_a[arb_idx*XLEN +: XLEN];
                    b_d       = req_b[arb_idx*XLEN +: XLEN];
                    ctrl_d    = req_ctrl[arb_idx*CTRLW +: CTRLW];
                    gnt_idx_d = arb_idx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d         = alu_result;
                flags_d[FLAG_C]  = alu_carry;
                flags_d[FLAG_V]  = alu_overflow;
                flags_d[FLAG_Z]  = alu_zero;
                flags_d[FLAG_N]  = alu_negative;
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gnt_idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    // Handshake outputs are decoded per requester; ready is suppressed while reset is held.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hs
        assign req_ready[gi] = rst && (state_q == ST_IDLE) && arb_gnt[gi];
        assign rsp_valid[gi] = (state_q == ST_RESP) && (gnt_idx_q == IDXW'(gi));
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small combinational ALU stub.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int CTRLW = 6;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*XLEN-1:0]  req_a;
    logic [NREQ*XLEN-1:0]  req_b;
    logic [NREQ*CTRLW-1:0] req_ctrl;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [XLEN-1:0]       rsp_result;
    logic [3:0]            rsp_flags;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [CTRLW-1:0]      alu_ctrl;
    logic [XLEN-1:0]       alu_result;
    logic                  alu_carry;
    logic                  alu_overflow;
    logic                  alu_zero;
    logic                  alu_negative;

    int checks_total;
    int checks_passed;

    alu_share_arbiter #(
        .NREQ  (NREQ),
        .XLEN  (XLEN),
        .CTRLW (CTRLW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ctrl     (req_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: ADD/SUB with carry/overflow, BNE returns 1 when operands are equal, others 0.
    logic [32:0] sum33;
    logic [32:0] dif33;
    always_comb begin
        sum33        = {1'b0, alu_a} + {1'b0, alu_b};
        dif33        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            6'b000000: begin
                alu_result   = sum33[31:0];
                alu_carry    = sum33[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
            end
            6'b000001: begin
                alu_result   = dif33[31:0];
                alu_carry    = dif33[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (dif33[31] != alu_a[31]);
            end
            6'b001011: alu_result = {31'd0, alu_a == alu_b};
            default:   alu_result = '0;
        endcase
        alu_zero     = (alu_result == '0);
        alu_negative = alu_result[31];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-16s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] ctrl);
        req_a[idx*XLEN +: XLEN]     = a;
        req_b[idx*XLEN +: XLEN]     = b;
        req_ctrl[idx*CTRLW +: CTRLW] = ctrl;
    endtask

    // One complete transaction from requester idx; returns at a negedge in IDLE.
    task automatic do_op(input string tag, input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] ctrl,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        @(negedge clk);
        set_req(idx, a, b, ctrl);
        req_valid = onehot;
        #1;
        check({tag, "_rdy"}, 64'(req_ready), 64'(onehot));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check({tag, "_ctrl"}, 64'(alu_ctrl), 64'(ctrl));
        check({tag, "_exec_v"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(rsp_valid), 64'(onehot));
        check({tag, "_res"}, 64'(rsp_result), 64'(exp_res));
        check({tag, "_flg"}, 64'(rsp_flags), 64'(exp_flags));
        rsp_ready = onehot;
        @(negedge clk);
        rsp_ready = '0;
        check({tag, "_done"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    int seq_idx [4];
    int n_seen;
    logic [NREQ-1:0] exp_rr [4];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_flags", 64'(rsp_flags), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        rst = 1'b1;

        // Single transactions, flags = {C,V,Z,N}
        do_op("add5_7", 0, 32'd5, 32'd7, 6'b000000, 32'd12, 4'b0000);
        do_op("sub9_9", 0, 32'd9, 32'd9, 6'b000001, 32'd0, 4'b1010);
        do_op("bne3_3", 0, 32'd3, 32'd3, 6'b001011, 32'd1, 4'b0000);
        do_op("add_cy", 1, 32'hFFFF_FFFF, 32'd1, 6'b000000, 32'd0, 4'b1010);
        do_op("add_ov", 1, 32'h7FFF_FFFF, 32'd1, 6'b000000, 32'h8000_0000, 4'b0101);
        do_op("undef", 0, 32'd4, 32'd4, 6'b111111, 32'd0, 4'b0010);

        // Both requesters valid continuously from reset
        apply_reset();
        set_req(0, 32'd1, 32'd2, 6'b000000);
        set_req(1, 32'd10, 32'd20, 6'b000000);
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        n_seen = 0;
        for (int cyc = 0; cyc < 40 && n_seen < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                check($sformatf("rr_grant%0d", n_seen), 64'(rsp_valid), 64'(exp_rr[n_seen]));
                check($sformatf("rr_res%0d", n_seen), 64'(rsp_result),
                      (exp_rr[n_seen] == 2'b01) ? 64'd3 : 64'd30);
                seq_idx[n_seen] = int'(rsp_valid);
                n_seen++;
            end
        end
        check("rr_count", 64'(n_seen), 64'd4);
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);

        // Backpressure: response to req0 held while req1 waits
        apply_reset();
        set_req(0, 32'd5, 32'd7, 6'b000000);
        set_req(1, 32'd9, 32'd9, 6'b000001);
        req_valid = 2'b01;
        #1;
        check("bp_rdy0", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_vld%0d", i), 64'(rsp_valid), 64'b01);
            check($sformatf("bp_res%0d", i), 64'(rsp_result), 64'd12);
            check($sformatf("bp_flg%0d", i), 64'(rsp_flags), 64'd0);
            check($sformatf("bp_rdy%0d", i), 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        check("bp_release", 64'(rsp_valid), 64'd0);
        check("bp_rdy1", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("bp_r1_vld", 64'(rsp_valid), 64'b10);
        check("bp_r1_res", 64'(rsp_result), 64'd0);
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;

        // Reset during EXEC drops the transaction
        set_req(1, 32'd100, 32'd1, 6'b000001);
        set_req(0, 32'd2, 32'd2, 6'b000000);
        req_valid = 2'b10;
        #1;
        check("mr_rdy1", 64'(req_ready), 64'b10);
        @(negedge clk);
        check("mr_exec_ctrl", 64'(alu_ctrl), 64'b000001);
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mr_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("mr_alu_a", 64'(alu_a), 64'd0);
        rst = 1'b1;
        #1;
        check("mr_first_gnt", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mr_vld", 64'(rsp_valid), 64'b01);
        check("mr_res", 64'(rsp_result), 64'd4);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
